// File: rtl/serial_logic_unit_if.sv
// Operand/result bus of serial_logic_unit. The op select exists only when SLU_OPSEL_EN is defined.
interface serial_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SLU_OPSEL_EN
    logic [1:0]       op;
`endif
    logic             bit_out;
    logic             bit_valid;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       state_dbg;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a held valid must keep its payload stable, and ready may depend on the partner's valid.
    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SLU_OPSEL_EN
        input  op,
`endif
        output in_ready, bit_out, bit_valid, c, out_valid, state_dbg
    );

    modport master (
        output in_valid, a, b, out_ready,
`ifdef SLU_OPSEL_EN
        output op,
`endif
        input  in_ready, bit_out, bit_valid, c, out_valid, state_dbg
    );
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise gate: one result bit per clock LSB first, then the word on a valid/ready port.
// Define SLU_OPSEL_EN to add the AND/OR/XOR/NAND op select; otherwise the gate is fixed to AND.
module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_logic_unit_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             bit_last_q;
    logic             accept;
    logic             cur_bit;
`ifdef SLU_OPSEL_EN
    logic [1:0]       op_q;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
`ifdef SLU_OPSEL_EN
        unique case (op_q)
            2'b00:   cur_bit = a_q[idx_q] & b_q[idx_q];
            2'b01:   cur_bit = a_q[idx_q] | b_q[idx_q];
            2'b10:   cur_bit = a_q[idx_q] ^ b_q[idx_q];
            default: cur_bit = ~(a_q[idx_q] & b_q[idx_q]);
        endcase
`else
        cur_bit = a_q[idx_q] & b_q[idx_q];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_BUSY;
            S_BUSY: if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = bus.in_valid ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.bit_valid = 1'b0;
        bus.out_valid = 1'b0;
        bus.bit_out   = bit_last_q;
        unique case (state_q)
            S_IDLE: bus.in_ready = 1'b1;
            S_BUSY: begin
                bus.bit_valid = 1'b1;
                bus.bit_out   = cur_bit;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Shadow operands decouple the source from the serial walk; c keeps unwritten bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            bit_last_q <= 1'b0;
`ifdef SLU_OPSEL_EN
            op_q       <= 2'b00;
`endif
        end else if (accept) begin
            idx_q <= '0;
            a_q   <= bus.a;
            b_q   <= bus.b;
`ifdef SLU_OPSEL_EN
            op_q  <= bus.op;
`endif
        end else if (state_q == S_BUSY) begin
            c_q[idx_q] <= cur_bit;
            bit_last_q <= cur_bit;
            idx_q      <= idx_q + IW'(1);
        end
    end

    assign bus.c         = c_q;
    assign bus.state_dbg = state_q;
endmodule
